// File: rtl/mdu_iterative_if.sv
// rtl/mdu_iterative_if.sv - request/response bundle between EX stage and the iterative MDU
interface mdu_iterative_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      function_3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, function_3, operand_a, operand_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, function_3, operand_a, operand_b,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - RV32M multiply/divide unit, one radix-2 step per cycle on magnitudes
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  mdu_iterative_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     counter;
  logic [2:0]        op;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] acc;
  logic              neg_res;
  logic              neg_rem;
  logic [XLEN-1:0]   result_q;

  // Operand decode at capture time
  logic            in_mul, signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_by_zero, div_overflow, special;
  logic [XLEN-1:0] special_val;
  logic            accept;

  always_comb begin
    in_mul       = !bus.function_3[2];
    signed_a     = in_mul ? (bus.function_3 != 3'b011) : !bus.function_3[0];
    signed_b     = in_mul ? !bus.function_3[1]         : !bus.function_3[0];
    sign_a       = signed_a && bus.operand_a[XLEN-1];
    sign_b       = signed_b && bus.operand_b[XLEN-1];
    abs_a        = sign_a ? -bus.operand_a : bus.operand_a;
    abs_b        = sign_b ? -bus.operand_b : bus.operand_b;
    div_by_zero  = !in_mul && (bus.operand_b == '0);
    div_overflow = !in_mul && !bus.function_3[0]
                   && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (bus.operand_b == '1);
    special      = div_by_zero || div_overflow;
    if (div_by_zero)
      special_val = bus.function_3[1] ? bus.operand_a : '1;
    else
      special_val = bus.function_3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    accept = (state == IDLE) && bus.start && !bus.flush;
  end

  // Single step: acc = {high/remainder, low/quotient-being-built}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     r_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_val;
  logic              last_step;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    r_shift  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge   = r_shift >= {1'b0, mag_b};
    div_diff = r_shift[XLEN-1:0] - mag_b;
    div_next = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1}
                      : {r_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    acc_next = op[2] ? div_next : mul_next;

    prod_fix = neg_res ? -acc_next : acc_next;
    quot_fix = neg_res ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem_fix  = neg_rem ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    if (!op[2])
      final_val = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else
      final_val = op[1] ? rem_fix : quot_fix;
    last_step = (counter == CW'(XLEN - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_next = special ? DONE : CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        if (bus.flush)      state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // result only moves on entry to DONE, so a flushed op leaves it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      counter  <= '0;
      op       <= '0;
      mag_b    <= '0;
      acc      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      counter <= '0;
      op      <= bus.function_3;
      mag_b   <= abs_b;
      acc     <= {{XLEN{1'b0}}, abs_a};
      neg_res <= sign_a ^ sign_b;
      neg_rem <= sign_a;
      if (special) result_q <= special_val;
    end else if (state == CALC && !bus.flush) begin
      acc     <= acc_next;
      counter <= counter + CW'(1);
      if (last_step) result_q <= final_val;
    end
  end

  assign bus.result = result_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - directed self-checking bench for mdu_iterative
module tb_mdu_iterative;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mdu_iterative_if #(.XLEN(32)) bus ();
  mdu_iterative #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 presents start; lat is the cycle index in which done is expected.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    int busy_n;
    bus.function_3 = f3;
    bus.operand_a  = a;
    bus.operand_b  = b;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    n      = 1;
    busy_n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      step();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_busy"}, busy_n, lat - 1);
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_busy_at_done"}, bus.busy, 1'b0);
    step();
    chk({tag, "_pulse"}, bus.done, 1'b0);
  endtask

  initial begin
    int dn;
    logic [31:0] prev;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.flush      = 1'b0;
    bus.function_3 = 3'b000;
    bus.operand_a  = '0;
    bus.operand_b  = '0;
    step();
    step();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    rst = 1'b0;
    step();

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_op("divu_z", 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_z",  3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // flush in CALC cycle 10
    prev           = bus.result;
    bus.function_3 = 3'b000;
    bus.operand_a  = 32'd1000;
    bus.operand_b  = 32'd1000;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    chk("flush_busy_before", bus.busy, 1'b1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_busy", bus.busy, 1'b0);
    chk("flush_done", bus.done, 1'b0);
    chk("flush_result", bus.result, prev);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dn++;
      step();
    end
    chk("flush_no_done", dn, 0);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    // start held through CALC and DONE
    bus.function_3 = 3'b000;
    bus.operand_a  = 32'd2;
    bus.operand_b  = 32'd3;
    bus.start      = 1'b1;
    dn = 0;
    step();
    for (int i = 1; i < 34; i++) begin
      if (bus.done === 1'b1) dn++;
      step();
    end
    bus.start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dn++;
      step();
    end
    chk("held_start_dones", dn, 1);
    chk("held_start_result", bus.result, 32'd6);
    chk("held_start_idle", bus.busy, 1'b0);

    // reset in CALC cycle 5
    bus.function_3 = 3'b001;
    bus.operand_a  = 32'h12345678;
    bus.operand_b  = 32'h9ABCDEF0;
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 5; i++) step();
    chk("rst_mid_busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_busy", bus.busy, 1'b0);
    chk("rst_mid_done", bus.done, 1'b0);
    chk("rst_mid_result", bus.result, 32'h0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dn++;
      step();
    end
    chk("rst_mid_no_done", dn, 0);

    // start and flush together in IDLE
    bus.function_3 = 3'b000;
    bus.operand_a  = 32'd9;
    bus.operand_b  = 32'd9;
    bus.start      = 1'b1;
    bus.flush      = 1'b1;
    step();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("sf_busy", bus.busy, 1'b0);
    chk("sf_done", bus.done, 1'b0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) dn++;
      step();
    end
    chk("sf_no_activity", dn, 0);
    chk("sf_result", bus.result, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
